mercury_tank_rack: RTL
======================

# mercury_tank_rack

Behavioural model of one EDSAC memory rack: eight recirculating mercury delay-line tanks (up/down half-racks, tanks t0..t3). It is the far end of the tank decoder interface. It consumes the decoder's per-tank clear gates, the serial memory-input bit and the rack bit strobe. It returns each tank's emerging serial bit and the bit entering each tank.

## Interface
Parameters:
- TANK_BITS, 576, bit positions per tank (16 long words × 36).
- POS_W, $clog2(TANK_BITS), position counter width.

Ports:
- clk  in  1  system clock.
- cls  in  1  reset; synchronous, active-high.
- rack_clk  in  1  bit strobe; each high cycle advances all tanks one bit.
- rack_mib  in  1  serial memory-input bit.
- rack_{down,up}_t{0..3}_clr  in  1 each (8)  per-tank clear gate; high breaks recirculation and substitutes rack_mib.
- rack_{down,up}_mob_t{0..3}  out  1 each (8)  bit emerging from each tank.
- rack_{down,up}_t{0..3}_in  out  1 each (8)  bit entering each tank on the last advance.
- rack_pos  out  POS_W  current tank bit position.
- rack_sync  out  1  one-cycle pulse when an advance wraps position to 0.
- rack_busy  out  1  high while the post-reset clear sweep runs.

## Operation
- Storage: TANK_BITS words × 8 bits. Bit order is {up_t3, up_t2, up_t1, up_t0, down_t3, down_t2, down_t1, down_t0}. Read is combinational at rack_pos. Write occurs at the clock edge.
- FSM has two states: CLEAR and RUN.
- CLEAR is entered on cls from any state, including mid-sweep or mid-advance.
  - Writes all-zero to word sweep_pos each cycle, for sweep_pos = 0..TANK_BITS-1.
  - rack_clk, clr gates and rack_mib are ignored.
  - rack_busy=1.
  - After writing word TANK_BITS-1, moves to RUN with rack_pos=0.
- RUN, advance cycle (rack_clk=1):
  - old = mem[pos].
  - new[i] = clr[i] ? rack_mib : old[i].
  - mem[pos] ← new.
  - mob ← old.
  - in ← new.
  - pos ← (pos == TANK_BITS-1) ? 0 : pos+1.
  - rack_sync ← 1 if wrapping, else 0.
- RUN, idle cycle (rack_clk=0):
  - mem, mob, in and pos are held.
  - rack_sync ← 0.
- Clears are independent per tank. Any combination, including all eight, writes the same rack_mib bit to every selected tank.
- Recirculation invariant: a bit written at an advance re-emerges on mob exactly TANK_BITS advances later, regardless of idle gaps.

## Timing
- Reset values, in effect the cycle after cls is sampled high:
  - all mob = 0, all in = 0.
  - rack_pos = 0, rack_sync = 0, rack_busy = 1.
  - state = CLEAR, sweep_pos = 0.
- rack_busy falls on the edge that writes word TANK_BITS-1. First RUN cycle is TANK_BITS cycles after cls deasserts.
- Outputs are registered, with one-cycle latency from the rack_clk edge. mob/in show the values of the most recent advance until the next advance.
- cls held high restarts the sweep each cycle. The sweep completes only after cls is low for TANK_BITS cycles.
- rack_clk asserted on consecutive cycles gives one advance per cycle. There is no minimum spacing.
- rack_sync is high for exactly one cycle per TANK_BITS advances.

## Structure
- Shared package edsac_pkg provides:
  - TANK_BITS_DEFAULT = 576.
  - Tank index constants: DOWN_T0..UP_T3 = 0..7.
  - Typedef tank_vec_t (logic [7:0]).
- Sub-module tank_store: TANK_BITS × 8 array with asynchronous read and synchronous write enable. Mapping to LUTRAM is permitted.
- Top level holds the FSM, sweep and position counters, the merge mux, and the output registers.

## Test plan
Benches run with TANK_BITS=16.
1. Reset sweep: pulse cls 1 cycle, then hold rack_clk=1.
   - rack_busy is high for 16 cycles and rack_pos stays 0.
   - Next 16 advances give all mob=0.
   - rack_sync pulses once, on the 16th advance.
2. Single-tank write/recirculate: after sweep, up_t2_clr=1 with rack_mib=1 on advance 3 only.
   - up_t2_in=1 after advance 3.
   - up_t2_mob=1 after advance 19 (3+16).
   - All other mob stay 0.
3. Idle gaps: same as 2, with rack_clk low on random cycles (≥20 idle).
   - Bit still re-emerges after the 16th following advance.
   - Outputs hold during idle cycles.
4. Multi-clear: all eight clr=1, rack_mib pattern 0xA5A5 (LSB first) over 16 advances.
   - All eight mob replay 0xA5A5 on the next 16 advances with clr=0.
5. Overwrite: down_t0 loaded with all-ones, then one pass with down_t0_clr=1 and rack_mib=0.
   - Following pass: mob all 0 for down_t0.
   - Other tanks are untouched.
6. Reset mid-operation: cls at advance 7 of a loaded rack.
   - Sweep restarts at 0, rack_busy=1, all outputs 0.
   - Post-sweep pass reads all zeros.

Source files
------------

// File: rtl/edsac_pkg.sv
// Shared EDSAC memory definitions.
// Provides the default tank length, the bit index of each tank within a rack
// word, the rack word type and the rack FSM state encoding.
package edsac_pkg;

  localparam int TANK_BITS_DEFAULT = 576;  // 16 long words x 36 bits

  // Bit position of each tank inside a rack word
  localparam int DOWN_T0 = 0;
  localparam int DOWN_T1 = 1;
  localparam int DOWN_T2 = 2;
  localparam int DOWN_T3 = 3;
  localparam int UP_T0   = 4;
  localparam int UP_T1   = 5;
  localparam int UP_T2   = 6;
  localparam int UP_T3   = 7;

  typedef logic [7:0] tank_vec_t;

  typedef enum logic {
    RACK_CLEAR = 1'b0,
    RACK_RUN   = 1'b1
  } rack_state_e;

endpackage

// File: rtl/mercury_tank_rack_if.sv
// Tank decoder <-> memory rack link.
// master: decoder side (drives strobe, input bit and clear gates).
// slave : rack side (returns emerging/entering bits, position, sync, busy).
interface mercury_tank_rack_if #(
  parameter int POS_W = 10
);
  logic             rack_clk;
  logic             rack_mib;
  logic             rack_down_t0_clr, rack_down_t1_clr, rack_down_t2_clr, rack_down_t3_clr;
  logic             rack_up_t0_clr,   rack_up_t1_clr,   rack_up_t2_clr,   rack_up_t3_clr;
  logic             rack_down_mob_t0, rack_down_mob_t1, rack_down_mob_t2, rack_down_mob_t3;
  logic             rack_up_mob_t0,   rack_up_mob_t1,   rack_up_mob_t2,   rack_up_mob_t3;
  logic             rack_down_t0_in,  rack_down_t1_in,  rack_down_t2_in,  rack_down_t3_in;
  logic             rack_up_t0_in,    rack_up_t1_in,    rack_up_t2_in,    rack_up_t3_in;
  logic [POS_W-1:0] rack_pos;
  logic             rack_sync;
  logic             rack_busy;

  modport master (
    output rack_clk, rack_mib,
    output rack_down_t0_clr, rack_down_t1_clr, rack_down_t2_clr, rack_down_t3_clr,
    output rack_up_t0_clr,   rack_up_t1_clr,   rack_up_t2_clr,   rack_up_t3_clr,
    input  rack_down_mob_t0, rack_down_mob_t1, rack_down_mob_t2, rack_down_mob_t3,
    input  rack_up_mob_t0,   rack_up_mob_t1,   rack_up_mob_t2,   rack_up_mob_t3,
    input  rack_down_t0_in,  rack_down_t1_in,  rack_down_t2_in,  rack_down_t3_in,
    input  rack_up_t0_in,    rack_up_t1_in,    rack_up_t2_in,    rack_up_t3_in,
    input  rack_pos, rack_sync, rack_busy
  );

  modport slave (
    input  rack_clk, rack_mib,
    input  rack_down_t0_clr, rack_down_t1_clr, rack_down_t2_clr, rack_down_t3_clr,
    input  rack_up_t0_clr,   rack_up_t1_clr,   rack_up_t2_clr,   rack_up_t3_clr,
    output rack_down_mob_t0, rack_down_mob_t1, rack_down_mob_t2, rack_down_mob_t3,
    output rack_up_mob_t0,   rack_up_mob_t1,   rack_up_mob_t2,   rack_up_mob_t3,
    output rack_down_t0_in,  rack_down_t1_in,  rack_down_t2_in,  rack_down_t3_in,
    output rack_up_t0_in,    rack_up_t1_in,    rack_up_t2_in,    rack_up_t3_in,
    output rack_pos, rack_sync, rack_busy
  );

endinterface

// File: rtl/mercury_tank_rack_store.sv
// Rack storage: DEPTH words of one bit per tank.
// Ports: clk; we/addr/wdata synchronous write; rdata asynchronous read at addr.
// Single address port: the rack reads and rewrites the same word per cycle.
module mercury_tank_rack_store
  import edsac_pkg::*;
#(
  parameter int DEPTH = TANK_BITS_DEFAULT,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic      clk,
  input  logic      we,
  input  logic [AW-1:0] addr,
  input  tank_vec_t wdata,
  output tank_vec_t rdata
);

  tank_vec_t mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/mercury_tank_rack.sv
// One EDSAC memory rack: eight recirculating delay-line tanks.
// Ports: clk, cls (sync active-high reset), rack (slave side of the
// decoder link: strobe, input bit, clear gates in; mob/in bits, position,
// sync and busy out).
// After reset the rack sweeps every word to zero, then recirculates one bit
// position per rack_clk strobe.
module mercury_tank_rack
  import edsac_pkg::*;
#(
  parameter int TANK_BITS = TANK_BITS_DEFAULT,
  parameter int POS_W     = $clog2(TANK_BITS)
) (
  input  logic                 clk,
  input  logic                 cls,
  mercury_tank_rack_if.slave   rack
);

  localparam logic [POS_W-1:0] LAST = POS_W'(TANK_BITS - 1);

  rack_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d, sweep_q, sweep_d, addr;
  tank_vec_t        mob_q, mob_d, in_q, in_d;
  tank_vec_t        clr, old_w, new_w, wdata;
  logic             sync_q, sync_d, we;

  assign clr = {rack.rack_up_t3_clr,   rack.rack_up_t2_clr,
                rack.rack_up_t1_clr,   rack.rack_up_t0_clr,
                rack.rack_down_t3_clr, rack.rack_down_t2_clr,
                rack.rack_down_t1_clr, rack.rack_down_t0_clr};

  // Cleared tanks take the input bit, the rest recirculate
  assign new_w = (old_w & ~clr) | ({8{rack.rack_mib}} & clr);

  mercury_tank_rack_store #(.DEPTH(TANK_BITS), .AW(POS_W)) u_store (
    .clk   (clk),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (old_w)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    sweep_d = sweep_q;
    mob_d   = mob_q;
    in_d    = in_q;
    sync_d  = 1'b0;
    we      = 1'b0;
    addr    = pos_q;
    wdata   = new_w;
    case (state_q)
      RACK_CLEAR: begin
        addr  = sweep_q;
        we    = 1'b1;
        wdata = '0;
        if (sweep_q == LAST) begin
          state_d = RACK_RUN;
          sweep_d = '0;
          pos_d   = '0;
        end else begin
          sweep_d = sweep_q + POS_W'(1);
        end
      end
      RACK_RUN: begin
        if (rack.rack_clk) begin
          we     = 1'b1;
          mob_d  = old_w;
          in_d   = new_w;
          sync_d = (pos_q == LAST);
          pos_d  = (pos_q == LAST) ? '0 : pos_q + POS_W'(1);
        end
      end
      default: state_d = RACK_CLEAR;
    endcase
    // Reset cycle writes nothing; the sweep that follows clears every word
    if (cls) we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (cls) begin
      state_q <= RACK_CLEAR;
      pos_q   <= '0;
      sweep_q <= '0;
      mob_q   <= '0;
      in_q    <= '0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      sweep_q <= sweep_d;
      mob_q   <= mob_d;
      in_q    <= in_d;
      sync_q  <= sync_d;
    end
  end

  assign rack.rack_down_mob_t0 = mob_q[DOWN_T0];
  assign rack.rack_down_mob_t1 = mob_q[DOWN_T1];
  assign rack.rack_down_mob_t2 = mob_q[DOWN_T2];
  assign rack.rack_down_mob_t3 = mob_q[DOWN_T3];
  assign rack.rack_up_mob_t0   = mob_q[UP_T0];
  assign rack.rack_up_mob_t1   = mob_q[UP_T1];
  assign rack.rack_up_mob_t2   = mob_q[UP_T2];
  assign rack.rack_up_mob_t3   = mob_q[UP_T3];

  assign rack.rack_down_t0_in  = in_q[DOWN_T0];
  assign rack.rack_down_t1_in  = in_q[DOWN_T1];
  assign rack.rack_down_t2_in  = in_q[DOWN_T2];
  assign rack.rack_down_t3_in  = in_q[DOWN_T3];
  assign rack.rack_up_t0_in    = in_q[UP_T0];
  assign rack.rack_up_t1_in    = in_q[UP_T1];
  assign rack.rack_up_t2_in    = in_q[UP_T2];
  assign rack.rack_up_t3_in    = in_q[UP_T3];

  assign rack.rack_pos  = pos_q;
  assign rack.rack_sync = sync_q;
  assign rack.rack_busy = (state_q == RACK_CLEAR);

endmodule
